// File: rtl/spi_reg_ctrl_if.sv
// Bus bundle between the SPI frame controller, the byte-wide SPI slave and
// the measurement register bank. The master modport is the controller's
// view; the slave modport is the view of the surrounding logic.
interface spi_reg_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    logic                  cs;
    logic [7:0]            rxData;
    logic                  rxValid;
    logic [7:0]            txData;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic [7:0]            regWrData;
    logic                  regWr;
    logic                  regRd;
    logic [7:0]            regRdData;
    logic                  busy;

    modport master (
        input  cs, rxData, rxValid, regRdData,
        output txData, regAddr, regWrData, regWr, regRd, busy
    );

    modport slave (
        output cs, rxData, rxValid, regRdData,
        input  txData, regAddr, regWrData, regWr, regRd, busy
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frame-level command controller behind the byte-wide SPI slave.
// Each chip-select frame is one command byte (bit7 = read, bits6:0 = start
// address) followed by data bytes; the address auto-increments per byte.
// Optional macro SPI_REG_CTRL_STATUS_EN: the first byte returned in every
// frame is a status byte {ovr, 3'b000, frameCnt[3:0]}; without it that byte
// is 8'h00 and the overrun flag / frame counter do not exist.
module spi_reg_ctrl #(
    parameter int unsigned REG_COUNT      = 16,
    parameter int unsigned ADDR_WIDTH     = 7,
    parameter logic [7:0]  OOR_READ_VALUE = 8'hFF
) (
    input  logic           clk,
    input  logic           rest,
    spi_reg_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CMD,
        WR_DATA,
        RD_FETCH,
        RD_DATA
    } state_t;

    // Range limits widened to 8 bits so every compare is width-matched.
    localparam logic [7:0] REG_COUNT8 = 8'(REG_COUNT);
    localparam logic [7:0] REG_LAST8  = 8'(REG_COUNT - 1);
    localparam logic [7:0] ADDR_SPAN8 = 8'(1 << ADDR_WIDTH);

    // cs synchroniser, edge history and rxValid edge detection
    logic       cs_meta_q, cs_sync_q, cs_prev_q;
    logic [1:0] sync_ok_q;
    logic       armed_q;
    logic       rxv_q, rx_q;

    // controller state
    state_t                state_q, state_d;
    logic [7:0]            txData_q, tx_d;
    logic [ADDR_WIDTH-1:0] regAddr_q, addr_d;
    logic [7:0]            regWrData_q, wdata_d;
    logic                  regWr_q, wr_d;
    logic                  regRd_q, rd_d;
    logic                  inc_pend_q, inc_pend_d;
    logic                  rd_issued_q, rd_issued_d;
    logic                  hi_q, hi_d;

    logic                  cs_fall;
    logic [7:0]            addr_ext;
    logic                  addr_valid;
    logic                  cmd_valid;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [7:0]            status_byte;

`ifdef SPI_REG_CTRL_STATUS_EN
    logic       ovr_q;
    logic [7:0] frame_cnt_q;
    logic       frame_start, frame_end, overrun;
    assign status_byte = {ovr_q, 3'b000, frame_cnt_q[3:0]};
`else
    assign status_byte = 8'h00;
`endif

    // A falling cs only starts a frame once cs has been seen high through a
    // real (not reset-forced) synchroniser sample; after a mid-frame reset
    // the rest of that frame is therefore ignored.
    assign cs_fall = cs_prev_q & ~cs_sync_q;

    // hi_q marks a command address with bits above ADDR_WIDTH set; it keeps
    // the whole frame out of range even though regAddr only holds low bits.
    assign addr_ext   = 8'(regAddr_q);
    assign addr_valid = ~hi_q && (addr_ext < REG_COUNT8);
    assign cmd_valid  = ({1'b0, bus.rxData[6:0]} < REG_COUNT8);
    assign addr_inc   = (addr_ext == REG_LAST8) ? '0 : regAddr_q + 1'b1;

    // Synchronise cs, track whether the synchroniser holds real samples and
    // turn the multi-cycle rxValid pulse into a one-clk registered event.
    always_ff @(posedge clk) begin
        if (!rest) begin
            cs_meta_q <= 1'b1;
            cs_sync_q <= 1'b1;
            cs_prev_q <= 1'b1;
            sync_ok_q <= 2'b00;
            armed_q   <= 1'b0;
            rxv_q     <= 1'b0;
            rx_q      <= 1'b0;
        end else begin
            cs_meta_q <= bus.cs;
            cs_sync_q <= cs_meta_q;
            cs_prev_q <= cs_sync_q;
            sync_ok_q <= {sync_ok_q[0], 1'b1};
            armed_q   <= armed_q | (sync_ok_q[1] & cs_sync_q);
            rxv_q     <= bus.rxValid;
            rx_q      <= bus.rxValid & ~rxv_q;
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rest) begin
            state_q     <= IDLE;
            txData_q    <= 8'h00;
            regAddr_q   <= '0;
            regWrData_q <= 8'h00;
            regWr_q     <= 1'b0;
            regRd_q     <= 1'b0;
            inc_pend_q  <= 1'b0;
            rd_issued_q <= 1'b0;
            hi_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            txData_q    <= tx_d;
            regAddr_q   <= addr_d;
            regWrData_q <= wdata_d;
            regWr_q     <= wr_d;
            regRd_q     <= rd_d;
            inc_pend_q  <= inc_pend_d;
            rd_issued_q <= rd_issued_d;
            hi_q        <= hi_d;
        end
    end

    // Next-state and output decode; strobes default low so each is one clk.
    always_comb begin
        state_d     = state_q;
        tx_d        = txData_q;
        addr_d      = regAddr_q;
        wdata_d     = regWrData_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        inc_pend_d  = 1'b0;
        rd_issued_d = rd_issued_q;
        hi_d        = hi_q;
`ifdef SPI_REG_CTRL_STATUS_EN
        frame_start = 1'b0;
        frame_end   = 1'b0;
        overrun     = 1'b0;
`endif

        // Address advances one clk after a write strobe (in or out of range).
        if (inc_pend_q) begin
            addr_d = addr_inc;
        end

        if (state_q == IDLE) begin
            if (cs_fall && armed_q) begin
                state_d = WAIT_CMD;
                tx_d    = status_byte;
`ifdef SPI_REG_CTRL_STATUS_EN
                frame_start = 1'b1;
`endif
            end
        end else if (cs_sync_q) begin
            // Frame end: no new strobe, txData held.
            state_d = IDLE;
`ifdef SPI_REG_CTRL_STATUS_EN
            frame_end = 1'b1;
`endif
        end else begin
            case (state_q)
                WAIT_CMD: begin
                    if (rx_q) begin
                        addr_d = bus.rxData[ADDR_WIDTH-1:0];
                        hi_d   = ({1'b0, bus.rxData[6:0]} >= ADDR_SPAN8);
                        if (bus.rxData[7]) begin
                            state_d     = RD_FETCH;
                            rd_issued_d = 1'b1;
                            rd_d        = cmd_valid;
                        end else begin
                            state_d = WR_DATA;
                            tx_d    = 8'h00;
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_q) begin
                        wdata_d    = bus.rxData;
                        wr_d       = addr_valid;
                        inc_pend_d = 1'b1;
                    end
                end
                RD_FETCH: begin
`ifdef SPI_REG_CTRL_STATUS_EN
                    overrun = rx_q;
`endif
                    if (!rd_issued_q) begin
                        rd_d        = addr_valid;
                        rd_issued_d = 1'b1;
                    end else begin
                        tx_d    = addr_valid ? bus.regRdData : OOR_READ_VALUE;
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rx_q) begin
                        addr_d      = addr_inc;
                        rd_issued_d = 1'b0;
                        state_d     = RD_FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef SPI_REG_CTRL_STATUS_EN
    // Sticky overrun flag (cleared when the status byte is staged) and
    // completed-frame counter.
    always_ff @(posedge clk) begin
        if (!rest) begin
            ovr_q       <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            if (overrun) begin
                ovr_q <= 1'b1;
            end else if (frame_start) begin
                ovr_q <= 1'b0;
            end
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 8'h01;
            end
        end
    end
`endif

    assign bus.txData    = txData_q;
    assign bus.regAddr   = regAddr_q;
    assign bus.regWrData = regWrData_q;
    assign bus.regWr     = regWr_q;
    assign bus.regRd     = regRd_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
